ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the banked even/odd byte RAM (RAM window 0x4000-SIZE to 0x3fff, 16-bit bus split into an even bank and an odd bank).
- Accepts byte or 16-bit word requests from requester A (CPU) and requester B (loader/debug), and steers addresses and data onto the bank ports, including unaligned words that straddle the two banks.
- Handles the RAM's one-cycle synchronous read latency and flags accesses outside the RAM window.

Parameters:
SIZE, 1024, RAM bytes (1024/2048/4096/8192); RAMBASE = 16'h4000 - SIZE

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
a_req  in  1  A request; held, with fields stable, until a_ack
a_we  in  1  A write (1) / read (0)
a_word  in  1  A 16-bit access (1) / byte (0)
a_addr  in  16  A byte address
a_wdata  in  16  A write data; byte writes use [7:0]
a_ack  out  1  A one-cycle completion pulse
a_rdata  out  16  A read data, valid with a_ack
a_err  out  1  A out-of-range flag, valid with a_ack
b_req, b_we, b_word, b_addr, b_wdata, b_ack, b_rdata, b_err: same as A, for requester B
ram_read_addr_even  out  15  even-bank read row, absolute (byte address >> 1)
ram_read_data_even  in  8  even-bank read data, one cycle after address
ram_write_addr_even  out  15  even-bank write row
ram_write_data_even  out  8  even-bank write data
ram_write_en_even  out  1  even-bank write strobe
ram_read_addr_odd, ram_read_data_odd, ram_write_addr_odd, ram_write_data_odd, ram_write_en_odd: same as even, for the odd bank

Behaviour:
- Operation order: each transaction runs IDLE -> ACCESS -> DONE -> IDLE, 3 cycles, for reads and writes alike. Requests are sampled only in IDLE.
- IDLE: if any request is pending, grant it. Latch the winner's fields, compute the range check and lane map, go to ACCESS.
- ACCESS: bank addresses are driven from latched values.
  - Write: the write enables are asserted for this cycle only.
  - Read: the address is presented; bank data returns in the next cycle.
- DONE: assert the winner's ack for one cycle, with rdata/err. Return to IDLE.
- Back-to-back requests: a req still high in IDLE after its ack counts as a new request. Minimum spacing is 3 cycles per transaction.
- Arbitration: fixed priority, A over B. If both are pending, A is granted; B waits.
- Lane map (little-endian; row = addr[15:1]):
  - byte, addr[0]=0: even bank, row.
  - byte, addr[0]=1: odd bank, row.
  - word, aligned: even bank = low byte, odd bank = high byte, both at row.
  - word, unaligned: odd bank = low byte at row; even bank = high byte at row+1.
- Read data: byte -> {8'h00, byte}; word -> {high, low}.
- Range check:
  - err=1 if addr < RAMBASE, or if the last byte (addr+word) > 16'h3fff. A word at 0x3fff is an error.
  - On err: no write enable, rdata=16'h0000, ack still pulses in DONE.
- Unused bank on byte access: write enable 0; address is don't-care but stable.
- Reset values:
  - state IDLE
  - a_ack=b_ack=0, a_err=b_err=0
  - a_rdata=b_rdata=0
  - all ram write enables 0, all ram addresses and write data 0
- Reset mid-operation:
  - The write enables are gated by !reset, so no write occurs in the reset cycle.
  - The pending transaction is dropped without ack.
  - Requesters re-issue after reset.
- Simultaneous events: a req that rises during ACCESS or DONE is served in the following IDLE.

Optional Feature:
RAM_ARB_RR_EN
- Defined: round-robin arbitration. A one-bit last-grant register prefers the requester not granted last. On reset it is set so that A wins first.
- Undefined: fixed priority, A over B. B can be starved by a continuously requesting A.

Decomposition:
- Package ram_arb_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - RAM_TOP = 16'h4000
  - function in_range(addr, word, rambase)
  - requester-index typedef
- Sub-module ram_lane_map: combinational steering of address and write data to bank row/data/enable, plus read-data reassembly from the two banks.

Test Plan:
- A byte write 0x3c05 := 0xAB, then byte read 0x3c05 -> odd bank row 0x1e02 written; read returns 0x00AB, ack 3 cycles after req.
- A word write 0x3c07 := 0x1234 (unaligned) -> odd row 0x1e03 gets 0x34, even row 0x1e04 gets 0x12; word read 0x3c07 returns 0x1234.
- SIZE=1024: word read 0x3bfe and word write 0x3fff -> err=1, no write enable, rdata 0; word at 0x3ffe ok.
- a_req and b_req asserted together, both held -> grants A,B,A,B with RAM_ARB_RR_EN; A,A,A without it, B never acked.
- reset asserted in the ACCESS cycle of a write -> no write enable, no ack, state IDLE next cycle, all outputs zero.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types, constants and helpers for the even/odd byte RAM
// arbiter.
//   state_e   : transaction sequencer states (IDLE -> ACCESS -> DONE)
//   req_idx_e : identifies requester A (CPU) or requester B (loader/debug)
//   RAM_TOP   : first byte address above the RAM window
//   in_range  : window check for a byte or word access
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

    localparam logic [15:0] RAM_TOP = 16'h4000;

    // True when every byte touched by the access lies in [rambase, RAM_TOP-1].
    // The last-byte sum is carried in 17 bits so that 0xffff plus one does not
    // wrap back into the window.
    function automatic logic in_range(input logic [15:0] addr,
                                      input logic        word,
                                      input logic [15:0] rambase);
        logic [16:0] last_byte;
        last_byte = {1'b0, addr} + {16'd0, word};
        return (addr >= rambase) && (last_byte <= {1'b0, RAM_TOP - 16'd1});
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/acknowledge bundle for one RAM requester.
//   req   : request, held with stable fields until ack
//   we    : write (1) / read (0)
//   word  : 16-bit access (1) / byte access (0)
//   addr  : byte address
//   wdata : write data, byte writes use [7:0]
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack
//   err   : out-of-window flag, valid with ack
// master modport is the requester side, slave modport is the arbiter side.
interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        err;

    modport master (
        output req, we, word, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, word, addr, wdata,
        output ack, rdata, err
    );
endinterface

// File: rtl/ram_arbiter_lane_map.sv
// ram_lane_map: combinational steering between a byte/word request and the
// even/odd byte banks (little-endian, row = addr[15:1]).
//   Write side inputs : addr, word, we, ok (access inside window), wdata
//   Write side outputs: even_row/odd_row, even_wdata/odd_wdata,
//                       even_we/odd_we
//   Read side inputs  : rd_word, rd_addr0 (latched access shape),
//                       rd_data_even/rd_data_odd (bank read data)
//   Read side output  : rd_data, {8'h00, byte} or {high, low}
module ram_lane_map (
    input  logic [15:0] addr,
    input  logic        word,
    input  logic        we,
    input  logic        ok,
    input  logic [15:0] wdata,
    output logic [14:0] even_row,
    output logic [14:0] odd_row,
    output logic [7:0]  even_wdata,
    output logic [7:0]  odd_wdata,
    output logic        even_we,
    output logic        odd_we,
    input  logic        rd_word,
    input  logic        rd_addr0,
    input  logic [7:0]  rd_data_even,
    input  logic [7:0]  rd_data_odd,
    output logic [15:0] rd_data
);

    logic [14:0] row_s;
    logic [14:0] row_next_s;
    logic        wr_s;

    assign row_s      = addr[15:1];
    assign row_next_s = row_s + 15'd1;
    assign wr_s       = we & ok;

    // Route address and write data to the bank(s) the access touches. The
    // untouched bank on a byte access keeps the request row so its address
    // stays stable, with its strobe held low.
    always_comb begin
        even_row   = row_s;
        odd_row    = row_s;
        even_wdata = 8'h00;
        odd_wdata  = 8'h00;
        even_we    = 1'b0;
        odd_we     = 1'b0;
        if (!word) begin
            if (!addr[0]) begin
                even_wdata = wdata[7:0];
                even_we    = wr_s;
            end else begin
                odd_wdata  = wdata[7:0];
                odd_we     = wr_s;
            end
        end else if (!addr[0]) begin
            even_wdata = wdata[7:0];
            odd_wdata  = wdata[15:8];
            even_we    = wr_s;
            odd_we     = wr_s;
        end else begin
            // Unaligned word: low byte sits in the odd bank at this row, the
            // high byte in the even bank of the next row.
            odd_wdata  = wdata[7:0];
            even_row   = row_next_s;
            even_wdata = wdata[15:8];
            even_we    = wr_s;
            odd_we     = wr_s;
        end
    end

    // Reassemble read data from the two bank outputs.
    always_comb begin
        rd_data = 16'h0000;
        if (!rd_word) begin
            if (rd_addr0) begin
                rd_data = {8'h00, rd_data_odd};
            end else begin
                rd_data = {8'h00, rd_data_even};
            end
        end else if (!rd_addr0) begin
            rd_data = {rd_data_odd, rd_data_even};
        end else begin
            rd_data = {rd_data_even, rd_data_odd};
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter and 3-cycle sequencer for the banked
// even/odd byte RAM occupying 0x4000-SIZE .. 0x3fff.
//   clk, reset        : clock, synchronous active-high reset
//   a, b              : requester bundles (ram_arbiter_if.slave); A is CPU,
//                       B is loader/debug
//   ram_*_even/_odd   : bank read row/data and write row/data/strobe; rows
//                       are absolute (byte address >> 1)
// Build option: RAM_ARB_RR_EN selects round-robin arbitration; without it A
// has fixed priority over B.
// Each transaction runs IDLE -> ACCESS -> DONE. Bank addresses, data and
// strobes are registered on entry to ACCESS; the bank returns read data in
// DONE, where ack/err are driven.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    ram_arbiter_if.slave a,
    ram_arbiter_if.slave b,
    output logic [14:0] ram_read_addr_even,
    input  logic [7:0]  ram_read_data_even,
    output logic [14:0] ram_write_addr_even,
    output logic [7:0]  ram_write_data_even,
    output logic        ram_write_en_even,
    output logic [14:0] ram_read_addr_odd,
    input  logic [7:0]  ram_read_data_odd,
    output logic [14:0] ram_write_addr_odd,
    output logic [7:0]  ram_write_data_odd,
    output logic        ram_write_en_odd
);

    localparam logic [15:0] RAMBASE = RAM_TOP - 16'(SIZE);

    state_e      state_r;
    req_idx_e    owner_r;
    logic        we_r;
    logic        word_r;
    logic        addr0_r;
    logic        err_r;
    logic [14:0] even_row_r;
    logic [14:0] odd_row_r;
    logic [7:0]  even_wdata_r;
    logic [7:0]  odd_wdata_r;
    logic        even_we_r;
    logic        odd_we_r;
    logic        a_ack_r;
    logic        b_ack_r;
    logic        a_err_r;
    logic        b_err_r;
`ifdef RAM_ARB_RR_EN
    req_idx_e    last_grant_r;
`endif

    logic        grant_valid_s;
    req_idx_e    grant_s;
    logic        sel_we_s;
    logic        sel_word_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;
    logic        range_ok_s;
    logic [14:0] lane_even_row_s;
    logic [14:0] lane_odd_row_s;
    logic [7:0]  lane_even_wdata_s;
    logic [7:0]  lane_odd_wdata_s;
    logic        lane_even_we_s;
    logic        lane_odd_we_s;
    logic [15:0] rd_data_s;
    logic [15:0] rd_result_s;
    logic        a_ack_s;
    logic        b_ack_s;

    // Pick the requester to serve in IDLE.
    always_comb begin
        grant_valid_s = a.req | b.req;
        grant_s       = REQ_A;
`ifdef RAM_ARB_RR_EN
        if (a.req && b.req) begin
            grant_s = (last_grant_r == REQ_A) ? REQ_B : REQ_A;
        end else if (a.req) begin
            grant_s = REQ_A;
        end else begin
            grant_s = REQ_B;
        end
`else
        if (a.req) begin
            grant_s = REQ_A;
        end else begin
            grant_s = REQ_B;
        end
`endif
    end

    // Multiplex the winning requester's fields.
    always_comb begin
        sel_we_s    = a.we;
        sel_word_s  = a.word;
        sel_addr_s  = a.addr;
        sel_wdata_s = a.wdata;
        if (grant_s == REQ_B) begin
            sel_we_s    = b.we;
            sel_word_s  = b.word;
            sel_addr_s  = b.addr;
            sel_wdata_s = b.wdata;
        end else begin
            sel_we_s    = a.we;
            sel_word_s  = a.word;
            sel_addr_s  = a.addr;
            sel_wdata_s = a.wdata;
        end
    end

    assign range_ok_s = in_range(sel_addr_s, sel_word_s, RAMBASE);

    ram_lane_map u_lane_map (
        .addr         (sel_addr_s),
        .word         (sel_word_s),
        .we           (sel_we_s),
        .ok           (range_ok_s),
        .wdata        (sel_wdata_s),
        .even_row     (lane_even_row_s),
        .odd_row      (lane_odd_row_s),
        .even_wdata   (lane_even_wdata_s),
        .odd_wdata    (lane_odd_wdata_s),
        .even_we      (lane_even_we_s),
        .odd_we       (lane_odd_we_s),
        .rd_word      (word_r),
        .rd_addr0     (addr0_r),
        .rd_data_even (ram_read_data_even),
        .rd_data_odd  (ram_read_data_odd),
        .rd_data      (rd_data_s)
    );

    // Transaction sequencer with registered bank controls and ack/err flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= REQ_A;
            we_r         <= 1'b0;
            word_r       <= 1'b0;
            addr0_r      <= 1'b0;
            err_r        <= 1'b0;
            even_row_r   <= 15'd0;
            odd_row_r    <= 15'd0;
            even_wdata_r <= 8'h00;
            odd_wdata_r  <= 8'h00;
            even_we_r    <= 1'b0;
            odd_we_r     <= 1'b0;
            a_ack_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            a_err_r      <= 1'b0;
            b_err_r      <= 1'b0;
`ifdef RAM_ARB_RR_EN
            // B counts as last granted so that A wins the first contest.
            last_grant_r <= REQ_B;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    a_err_r <= 1'b0;
                    b_err_r <= 1'b0;
                    if (grant_valid_s) begin
                        owner_r      <= grant_s;
                        we_r         <= sel_we_s;
                        word_r       <= sel_word_s;
                        addr0_r      <= sel_addr_s[0];
                        err_r        <= ~range_ok_s;
                        even_row_r   <= lane_even_row_s;
                        odd_row_r    <= lane_odd_row_s;
                        even_wdata_r <= lane_even_wdata_s;
                        odd_wdata_r  <= lane_odd_wdata_s;
                        even_we_r    <= lane_even_we_s;
                        odd_we_r     <= lane_odd_we_s;
`ifdef RAM_ARB_RR_EN
                        last_grant_r <= grant_s;
`endif
                        state_r      <= ACCESS;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                ACCESS: begin
                    even_we_r <= 1'b0;
                    odd_we_r  <= 1'b0;
                    a_ack_r   <= (owner_r == REQ_A);
                    b_ack_r   <= (owner_r == REQ_B);
                    a_err_r   <= (owner_r == REQ_A) & err_r;
                    b_err_r   <= (owner_r == REQ_B) & err_r;
                    state_r   <= DONE;
                end
                DONE: begin
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    a_err_r <= 1'b0;
                    b_err_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    even_we_r <= 1'b0;
                    odd_we_r  <= 1'b0;
                    a_ack_r   <= 1'b0;
                    b_ack_r   <= 1'b0;
                    a_err_r   <= 1'b0;
                    b_err_r   <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Strobes and acks are masked by reset so a transaction caught by reset
    // neither writes nor completes.
    assign ram_write_en_even   = even_we_r & ~reset;
    assign ram_write_en_odd    = odd_we_r & ~reset;
    assign ram_read_addr_even  = even_row_r;
    assign ram_write_addr_even = even_row_r;
    assign ram_write_data_even = even_wdata_r;
    assign ram_read_addr_odd   = odd_row_r;
    assign ram_write_addr_odd  = odd_row_r;
    assign ram_write_data_odd  = odd_wdata_r;

    assign a_ack_s = a_ack_r & ~reset;
    assign b_ack_s = b_ack_r & ~reset;

    // Bank data only arrives in DONE, so rdata is formed from the live bank
    // outputs and forced to zero for writes, errors and outside the ack.
    assign rd_result_s = (err_r | we_r) ? 16'h0000 : rd_data_s;

    assign a.ack   = a_ack_s;
    assign a.err   = a_err_r & ~reset;
    assign a.rdata = a_ack_s ? rd_result_s : 16'h0000;
    assign b.ack   = b_ack_s;
    assign b.err   = b_err_r & ~reset;
    assign b.rdata = b_ack_s ? rd_result_s : 16'h0000;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench for ram_arbiter. The RAM is
// modelled as two synchronous byte banks; expected results come from a flat
// byte-addressed reference memory and the window rules.
module tb_ram_arbiter;

    localparam int          SIZE    = 1024;
    localparam logic [15:0] RAMBASE = 16'h4000 - 16'(SIZE);

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ram_read_addr_even;
    logic [7:0]  ram_read_data_even;
    logic [14:0] ram_write_addr_even;
    logic [7:0]  ram_write_data_even;
    logic        ram_write_en_even;
    logic [14:0] ram_read_addr_odd;
    logic [7:0]  ram_read_data_odd;
    logic [14:0] ram_write_addr_odd;
    logic [7:0]  ram_write_data_odd;
    logic        ram_write_en_odd;

    ram_arbiter_if a_if ();
    ram_arbiter_if b_if ();

    ram_arbiter #(.SIZE(SIZE)) dut (
        .clk                 (clk),
        .reset               (reset),
        .a                   (a_if),
        .b                   (b_if),
        .ram_read_addr_even  (ram_read_addr_even),
        .ram_read_data_even  (ram_read_data_even),
        .ram_write_addr_even (ram_write_addr_even),
        .ram_write_data_even (ram_write_data_even),
        .ram_write_en_even   (ram_write_en_even),
        .ram_read_addr_odd   (ram_read_addr_odd),
        .ram_read_data_odd   (ram_read_data_odd),
        .ram_write_addr_odd  (ram_write_addr_odd),
        .ram_write_data_odd  (ram_write_data_odd),
        .ram_write_en_odd    (ram_write_en_odd)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bank RAM model with a preload port used while the DUT is in reset.
    logic [7:0]  mem_even [0:32767];
    logic [7:0]  mem_odd  [0:32767];
    logic        preload_en = 1'b0;
    logic [14:0] preload_row;
    logic [7:0]  preload_even;
    logic [7:0]  preload_odd;
    int          strobes = 0;

    always @(posedge clk) begin
        if (preload_en) begin
            mem_even[preload_row] <= preload_even;
            mem_odd[preload_row]  <= preload_odd;
        end else begin
            if (ram_write_en_even) mem_even[ram_write_addr_even] <= ram_write_data_even;
            if (ram_write_en_odd)  mem_odd[ram_write_addr_odd]   <= ram_write_data_odd;
        end
        ram_read_data_even <= mem_even[ram_read_addr_even];
        ram_read_data_odd  <= mem_odd[ram_read_addr_odd];
        strobes <= strobes + int'(ram_write_en_even) + int'(ram_write_en_odd);
    end

    // Reference: flat byte memory plus window rules.
    logic [7:0] ref_mem [0:65535];

    function automatic bit exp_err(input logic [15:0] addr, input bit word);
        int last_byte;
        last_byte = int'(addr) + int'(word);
        return (int'(addr) < int'(RAMBASE)) || (last_byte > 32'h3fff);
    endfunction

    function automatic logic [7:0] bank_byte(input logic [15:0] ba);
        logic [14:0] r;
        r = ba[15:1];
        return ba[0] ? mem_odd[r] : mem_even[r];
    endfunction

    task automatic drive_req(input bit use_b, input bit req, input bit we, input bit word,
                             input logic [15:0] addr, input logic [15:0] wdata);
        if (use_b) begin
            b_if.we = we; b_if.word = word; b_if.addr = addr; b_if.wdata = wdata; b_if.req = req;
        end else begin
            a_if.we = we; a_if.word = word; a_if.addr = addr; a_if.wdata = wdata; a_if.req = req;
        end
    endtask

    // One transaction from an idle arbiter; checks latency, flags, data,
    // strobe count and bank contents against the reference.
    task automatic run_txn(input bit use_b, input bit we, input bit word,
                           input logic [15:0] addr, input logic [15:0] wdata);
        bit          e_err;
        logic [15:0] e_rdata;
        int          e_strobes;
        int          s0;
        int          lat;
        bit          got;
        logic [15:0] rd;
        logic        er;
        logic        other_ack;
        logic [15:0] a1;
        e_err     = exp_err(addr, word);
        a1        = addr + 16'd1;
        e_rdata   = 16'h0000;
        e_strobes = 0;
        if (!e_err && !we) e_rdata = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
        if (!e_err && we)  e_strobes = word ? 2 : 1;
        s0 = strobes;
        drive_req(use_b, 1'b1, we, word, addr, wdata);
        lat = 0; got = 1'b0; rd = 16'h0; er = 1'b0; other_ack = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (use_b ? b_if.ack : a_if.ack) begin
                got = 1'b1;
                rd  = use_b ? b_if.rdata : a_if.rdata;
                er  = use_b ? b_if.err : a_if.err;
                other_ack = use_b ? a_if.ack : b_if.ack;
            end
        end
        check_eq("ack_seen", 32'(got), 32'd1);
        check_eq("ack_latency", lat, 2);
        check_eq("other_ack", 32'(other_ack), 32'd0);
        check_eq("err", 32'(er), 32'(e_err));
        check_eq("rdata", 32'(rd), 32'(e_rdata));
        check_eq("write_strobes", strobes - s0, e_strobes);
        drive_req(use_b, 1'b0, we, word, addr, wdata);
        if (!e_err && we) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[a1] = wdata[15:8];
        end
        check_eq("bank_byte0", 32'(bank_byte(addr)), 32'(ref_mem[addr]));
        if (word && !exp_err(addr, 1'b0) && !exp_err(a1, 1'b0))
            check_eq("bank_byte1", 32'(bank_byte(a1)), 32'(ref_mem[a1]));
        @(negedge clk);
        check_eq("ack_pulse_end", 32'(use_b ? b_if.ack : a_if.ack), 32'd0);
    endtask

    initial begin : main
        int          n;
        int          cyc;
        int          s0;
        bit          use_b;
        logic [15:0] addr;

        reset = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = int'(RAMBASE); i < 32'h4000; i++) ref_mem[i] = 8'($urandom);
        for (int r = int'(RAMBASE) / 2; r < 32'h2000; r++) begin
            @(negedge clk);
            preload_en   = 1'b1;
            preload_row  = 15'(r);
            preload_even = ref_mem[2 * r];
            preload_odd  = ref_mem[2 * r + 1];
        end
        @(negedge clk);
        preload_en = 1'b0;
        @(negedge clk);
        check_eq("rst_a_ack", 32'(a_if.ack), 32'd0);
        check_eq("rst_b_ack", 32'(b_if.ack), 32'd0);
        check_eq("rst_err", 32'({a_if.err, b_if.err}), 32'd0);
        check_eq("rst_rdata", {a_if.rdata, b_if.rdata}, 32'd0);
        check_eq("rst_we", 32'({ram_write_en_even, ram_write_en_odd}), 32'd0);
        check_eq("rst_addr", 32'({ram_write_addr_even, ram_read_addr_odd}), 32'd0);
        check_eq("rst_wdata", 32'({ram_write_data_even, ram_write_data_odd}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn(1'b0, 1'b1, 1'b0, 16'h3c05, 16'h00ab);
        check_eq("odd_row_1e02", 32'(mem_odd[15'h1e02]), 32'h00ab);
        run_txn(1'b0, 1'b0, 1'b0, 16'h3c05, 16'h0000);
        run_txn(1'b0, 1'b1, 1'b1, 16'h3c07, 16'h1234);
        check_eq("odd_row_1e03", 32'(mem_odd[15'h1e03]), 32'h0034);
        check_eq("even_row_1e04", 32'(mem_even[15'h1e04]), 32'h0012);
        run_txn(1'b0, 1'b0, 1'b1, 16'h3c07, 16'h0000);
        run_txn(1'b1, 1'b0, 1'b1, 16'h3bfe, 16'h0000);
        run_txn(1'b0, 1'b1, 1'b1, 16'h3fff, 16'hbeef);
        run_txn(1'b1, 1'b1, 1'b1, 16'h3ffe, 16'hcafe);
        run_txn(1'b0, 1'b0, 1'b1, 16'h3ffe, 16'h0000);
        run_txn(1'b1, 1'b1, 1'b0, 16'h3bff, 16'h0055);
        run_txn(1'b1, 1'b0, 1'b0, 16'h3c00, 16'h0000);

        // Randomized single-requester traffic.
        for (int k = 0; k < 80; k++) begin
            use_b = 1'($urandom);
            if ($urandom_range(0, 7) == 0) addr = 16'($urandom);
            else addr = 16'h3bf0 + 16'($urandom_range(0, 32'h40f));
            run_txn(use_b, 1'($urandom), 1'($urandom), addr, 16'($urandom));
        end

        // Both requesters held: arbitration order.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 16'h3c10, 16'h0);
        drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'h3c11, 16'h0);
        n = 0; cyc = 0;
        while (n < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (a_if.ack || b_if.ack) begin
`ifdef RAM_ARB_RR_EN
                check_eq("arb_order_b", 32'(b_if.ack), 32'(n % 2 == 1));
`else
                check_eq("arb_order_b", 32'(b_if.ack), 32'd0);
`endif
                check_eq("arb_onehot", 32'(a_if.ack ^ b_if.ack), 32'd1);
                if (a_if.ack) check_eq("arb_a_rdata", 32'(a_if.rdata), {24'd0, ref_mem[16'h3c10]});
                if (b_if.ack) check_eq("arb_b_rdata", 32'(b_if.rdata), {24'd0, ref_mem[16'h3c11]});
                n++;
            end
        end
        check_eq("arb_ack_count", n, 6);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset during the ACCESS cycle of a write.
        s0 = strobes;
        drive_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h3c20, {8'h00, ~ref_mem[16'h3c20]});
        @(negedge clk);
        reset = 1'b1;
        a_if.req = 1'b0;
        #1;
        check_eq("midrst_we_gated", 32'({ram_write_en_even, ram_write_en_odd}), 32'd0);
        check_eq("midrst_no_ack", 32'({a_if.ack, b_if.ack}), 32'd0);
        @(negedge clk);
        check_eq("midrst_ack", 32'({a_if.ack, b_if.ack, a_if.err, b_if.err}), 32'd0);
        check_eq("midrst_addr", 32'({ram_write_addr_even, ram_write_addr_odd}), 32'd0);
        check_eq("midrst_wdata", 32'({ram_write_data_even, ram_write_data_odd}), 32'd0);
        check_eq("midrst_rdata", {a_if.rdata, b_if.rdata}, 32'd0);
        reset = 1'b0;
        check_eq("midrst_strobes", strobes - s0, 0);
        check_eq("midrst_mem", 32'(bank_byte(16'h3c20)), 32'(ref_mem[16'h3c20]));
        @(negedge clk);
        run_txn(1'b0, 1'b0, 1'b0, 16'h3c20, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
